ext_bus_arbiter: RTL and testbench
==================================

Name: ext_bus_arbiter

Overview:
- Shares the chip's single 8-bit bidirectional uio bus to external memory between two CPU requesters: instruction fetch (port 0) and data load/store (port 1).
- Uses round-robin arbitration and sequences each transaction as a multiplexed address/data transfer on uio.
- Sits between the CPU core and the top-level uio_in/uio_out/uio_oe pins, plus two control pins on uo_out[7] and a spare output.

Parameters:
- WAIT_CYCLES, 1, data-phase length in cycles for both read and write; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req0  in  1  fetch request, level; held until done0
- addr0  in  16  fetch address; read-only requester
- req1  in  1  data request, level; held until done1
- addr1  in  16  data address
- we1  in  1  1 = write, 0 = read
- wdata1  in  8  write data
- gnt  out  2  one-hot grant, bit k = requester k owns the bus
- done0  out  1  one-cycle completion pulse, requester 0
- done1  out  1  one-cycle completion pulse, requester 1
- rdata  out  8  read data; valid in the done cycle, held until the next read completes
- busy  out  1  high whenever state != IDLE
- uio_in  in  8  bus input path
- uio_out  out  8  bus output path
- uio_oe  out  8  bus output enable; all bits equal
- bus_ale  out  1  address-latch strobe to external memory
- bus_we  out  1  write qualifier to external memory

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - gnt=00, done0=done1=0, rdata=00, busy=0, uio_out=00, uio_oe=00, bus_ale=0, bus_we=0.
  - Round-robin pointer favours requester 0.
  - Wait counter cleared.
- Reset asserted mid-transaction aborts the transaction: no done pulse, and uio_oe=00 from the next edge.
- IDLE:
  - Bus released: uio_oe=00, bus_ale=0.
  - If either req is high at the edge, arbitrate, then latch addr, we and wdata from the winner into internal registers.
  - Set gnt to the winner and go to ADDR_HI.
  - Requester 0 always has an implicit we=0.
- Arbitration:
  - Single request wins outright.
  - If both are high, the pointer holder wins.
  - After each completed transaction the pointer moves to the other requester, regardless of whether it is requesting.
- ADDR_HI: uio_out=addr[15:8], uio_oe=FF, bus_ale=1, bus_we=we.
- ADDR_LO: uio_out=addr[7:0], uio_oe=FF, bus_ale=1, bus_we=we. Go to DATA_W if we=1, else TURN.
- DATA_W:
  - uio_out=wdata, uio_oe=FF, bus_ale=0, bus_we=1.
  - Lasts WAIT_CYCLES cycles, then go to DONE.
- TURN: uio_oe=00, bus_ale=0, bus_we=0 for one cycle (bus turnaround), then go to DATA_R.
- DATA_R:
  - uio_oe=00, lasts WAIT_CYCLES cycles.
  - uio_in is sampled into rdata on the last DATA_R cycle edge.
- DONE:
  - uio_oe=00, bus_ale=0, bus_we=0.
  - The done pulse for the granted requester is high for exactly this cycle; gnt is still valid.
  - Next edge: gnt=00, state goes to IDLE.
- Latency, counting the accepting IDLE edge as cycle 0:
  - Read: done at cycle 4+WAIT_CYCLES.
  - Write: done at cycle 3+WAIT_CYCLES.
  - Minimum one IDLE cycle between transactions.
- Latched fields:
  - A requester dropping req or changing addr/wdata mid-transaction has no effect; the transaction completes and done still pulses.
  - req still high in the IDLE cycle after DONE is treated as a new request.
- Wait counter:
  - Counter width is clog2(WAIT_CYCLES+1).
  - Loaded on entry to DATA_W or DATA_R; decrements to zero without wrap.
- Outputs are registered (state-decoded from registered state). No combinational path from req to uio pins.

Test Plan:
- Single fetch, WAIT_CYCLES=1: req0=1, addr0=0x12A5, external model drives uio_in=0x3C in DATA_R.
  - uio_out = 0x12 then 0xA5 with bus_ale=1.
  - One turnaround cycle with oe=00.
  - done0 at cycle 5, rdata=0x3C, gnt=01 throughout.
- Single write: req1=1, we1=1, addr1=0x00FF, wdata1=0x81.
  - Bus carries 0x00, 0xFF, then 0x81 with oe=FF and bus_we=1 through DATA_W.
  - done1 at cycle 4; rdata unchanged.
- Contention: req0 and req1 held high continuously, both reads.
  - Grants alternate 01, 10, 01, 10; the first winner after reset is requester 0.
  - Each transaction takes 6 cycles including the IDLE gap.
- Request withdrawal: req1 dropped and addr1 changed during ADDR_LO.
  - The original address is still driven, done1 still pulses, and no new transaction starts.
- Reset mid-op: rst_n low during DATA_W.
  - Next edge gives uio_oe=00, gnt=00, busy=0, and no done pulse.
  - After release, simultaneous requests grant requester 0 first.
- WAIT_CYCLES=3 read: DATA_R lasts 3 cycles, and rdata captures the uio_in value present on the third cycle, not the first.

Source files
------------

// File: rtl/ext_bus_arbiter_if.sv
// Requester, status and uio pin bundle for the external bus arbiter.
// The slave side is the arbiter; the master side is the CPU core plus pads.
interface ext_bus_arbiter_if;
  logic        req0;
  logic [15:0] addr0;
  logic        req1;
  logic [15:0] addr1;
  logic        we1;
  logic [7:0]  wdata1;
  logic [1:0]  gnt;
  logic        done0;
  logic        done1;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic        bus_ale;
  logic        bus_we;

  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, uio_in,
    input  gnt, done0, done1, rdata, busy, uio_out, uio_oe, bus_ale, bus_we
  );

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, uio_in,
    output gnt, done0, done1, rdata, busy, uio_out, uio_oe, bus_ale, bus_we
  );
endinterface

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio bus between fetch (port 0) and
// load/store (port 1) as multiplexed address/data transfers.
module ext_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  ext_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA_W, TURN, DATA_R, DONE
  } state_t;

  state_t           state;
  logic             ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      addr_q;
  logic             we_q;
  logic [7:0]       wdata_q;

  logic             pick1;
  logic [15:0]      addr_sel;
  logic             we_sel;

  // Port 1 wins when it is the only requester or when it holds the pointer.
  assign pick1    = bus.req1 & (~bus.req0 | ptr);
  assign addr_sel = pick1 ? bus.addr1 : bus.addr0;
  assign we_sel   = pick1 & bus.we1;

  // Outputs are loaded with the decode of the state being entered, so every
  // pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      bus.gnt     <= 2'b00;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.rdata   <= 8'h00;
      bus.busy    <= 1'b0;
      bus.uio_out <= 8'h00;
      bus.uio_oe  <= 8'h00;
      bus.bus_ale <= 1'b0;
      bus.bus_we  <= 1'b0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner       <= pick1;
            addr_q      <= addr_sel;
            we_q        <= we_sel;
            wdata_q     <= bus.wdata1;
            bus.gnt     <= pick1 ? 2'b10 : 2'b01;
            bus.busy    <= 1'b1;
            bus.uio_out <= addr_sel[15:8];
            bus.uio_oe  <= 8'hFF;
            bus.bus_ale <= 1'b1;
            bus.bus_we  <= we_sel;
            state       <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          bus.uio_out <= addr_q[7:0];
          state       <= ADDR_LO;
        end
        ADDR_LO: begin
          bus.bus_ale <= 1'b0;
          if (we_q) begin
            bus.uio_out <= wdata_q;
            bus.bus_we  <= 1'b1;
            cnt         <= CNT_LOAD;
            state       <= DATA_W;
          end else begin
            bus.uio_out <= 8'h00;
            bus.uio_oe  <= 8'h00;
            bus.bus_we  <= 1'b0;
            state       <= TURN;
          end
        end
        DATA_W: begin
          if (cnt > CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt         <= '0;
            bus.uio_out <= 8'h00;
            bus.uio_oe  <= 8'h00;
            bus.bus_we  <= 1'b0;
            bus.done0   <= ~owner;
            bus.done1   <= owner;
            state       <= DONE;
          end
        end
        TURN: begin
          cnt   <= CNT_LOAD;
          state <= DATA_R;
        end
        DATA_R: begin
          if (cnt > CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt       <= '0;
            bus.rdata <= bus.uio_in;
            bus.done0 <= ~owner;
            bus.done1 <= owner;
            state     <= DONE;
          end
        end
        DONE: begin
          // Pointer always passes to the other requester after a completion.
          ptr      <= ~owner;
          bus.gnt  <= 2'b00;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Scoreboard bench: two arbiters (WAIT_CYCLES 1 and 3), a uio memory model,
// and a monitor that reconstructs each bus transaction and checks it at done.
module tb_ext_bus_arbiter;

  typedef struct {
    int          port;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          zc;
    int          wc;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        req0_s   [2];
  logic        req1_s   [2];
  logic        we1_s    [2];
  logic [15:0] addr0_s  [2];
  logic [15:0] addr1_s  [2];
  logic [7:0]  wdata1_s [2];
  logic [7:0]  uio_s    [2];
  logic [7:0]  rd_base  [2];
  logic [1:0]  done_o   [2];
  logic        busy_o   [2];

  item_t exp_q [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    ext_bus_arbiter_if bif ();
    ext_bus_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
    );

    assign bif.req0   = req0_s[g];
    assign bif.addr0  = addr0_s[g];
    assign bif.req1   = req1_s[g];
    assign bif.addr1  = addr1_s[g];
    assign bif.we1    = we1_s[g];
    assign bif.wdata1 = wdata1_s[g];
    assign bif.uio_in = uio_s[g];
    assign done_o[g]  = {bif.done1, bif.done0};
    assign busy_o[g]  = bif.busy;

    // Memory model: junk during turnaround, base+j in the j-th read data cycle.
    int   j = -1;
    logic prev_ale = 1'b0;
    always @(negedge clk) begin
      if (prev_ale && !bif.bus_ale && bif.uio_oe == 8'h00 && bif.busy &&
          !bif.done0 && !bif.done1) begin
        j = 0;
        uio_s[g] = 8'hEE;
      end else if (j >= 0 && bif.busy && bif.uio_oe == 8'h00 &&
                   !bif.done0 && !bif.done1) begin
        j++;
        uio_s[g] = rd_base[g] + 8'(j);
      end else begin
        j = -1;
        uio_s[g] = 8'hEE;
      end
      prev_ale = bif.bus_ale;
    end

    int          cyc = 0, start = 0, ale_n = 0, nz = 0, nw = 0;
    bit          in_txn = 0, gnt_bad = 0;
    logic [7:0]  hi = 8'h00, lo = 8'h00, wb = 8'h00;
    logic [1:0]  g0 = 2'b00;
    logic        we_seen = 1'b0;
    item_t       e;
    always @(negedge clk) begin
      cyc++;
      if (bif.busy && !in_txn) begin
        in_txn  = 1;
        start   = cyc;
        ale_n   = 0;
        nz      = 0;
        nw      = 0;
        gnt_bad = 0;
        wb      = 8'h00;
        g0      = bif.gnt;
        we_seen = bif.bus_we;
      end
      if (in_txn) begin
        if (bif.gnt !== g0) gnt_bad = 1;
        if (bif.bus_ale) begin
          if (ale_n == 0) hi = bif.uio_out;
          else lo = bif.uio_out;
          ale_n++;
        end
        if (bif.uio_oe == 8'hFF && !bif.bus_ale && bif.bus_we) begin
          wb = bif.uio_out;
          nw++;
        end
        if (bif.uio_oe == 8'h00 && !bif.done0 && !bif.done1) nz++;
        if (bif.done0 || bif.done1) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_done", 32'(exp_q[g].size()), 1);
          end else begin
            e = exp_q[g].pop_front();
            chk("done_port",    bif.done1, e.port);
            chk("both_done",    bif.done0 & bif.done1, 0);
            chk("gnt",          g0, (e.port == 1) ? 2'b10 : 2'b01);
            chk("gnt_stable",   gnt_bad, 0);
            chk("addr",         {hi, lo}, e.addr);
            chk("ale_cycles",   ale_n, 2);
            chk("addr_bus_we",  we_seen, e.we);
            if (e.we) chk("wdata", wb, e.wdata);
            chk("rdata",        bif.rdata, e.rdata);
            chk("latency",      cyc - start + 1, e.lat);
            chk("oe_off_cycles", nz, e.zc);
            chk("data_w_cycles", nw, e.wc);
          end
          in_txn = 0;
        end else if (!bif.busy) begin
          in_txn = 0;
        end
      end
    end
  end

  task automatic do_txn(input int k, input int port, input logic [15:0] a,
                        input logic we, input logic [7:0] wd, input logic [7:0] base,
                        input logic [7:0] rd, input int lat, input int zc, input int wc);
    item_t it;
    logic  seen;
    it = '{port: port, addr: a, we: we, wdata: wd, rdata: rd, lat: lat, zc: zc, wc: wc};
    exp_q[k].push_back(it);
    rd_base[k] = base;
    if (port == 0) begin
      req0_s[k]  = 1'b1;
      addr0_s[k] = a;
    end else begin
      req1_s[k]   = 1'b1;
      addr1_s[k]  = a;
      we1_s[k]    = we;
      wdata1_s[k] = wd;
    end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = done_o[k][port];
    end
    chk("done_seen", seen, 1);
    req0_s[k] = 1'b0;
    req1_s[k] = 1'b0;
    @(negedge clk);
  endtask

  // Waits for cnt back-to-back completions; consecutive ones must be 6 apart.
  task automatic wait_dones(input int k, input int cnt);
    logic seen;
    int   gap;
    gap = 0;
    for (int t = 0; t < cnt; t++) begin
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        gap++;
        seen = |done_o[k];
      end
      chk("pair_done_seen", seen, 1);
      if (t > 0) chk("done_spacing", gap, 6);
      gap = 0;
    end
    req0_s[k] = 1'b0;
    req1_s[k] = 1'b0;
    @(negedge clk);
  endtask

  function automatic item_t mk_rd(input int port, input logic [15:0] a, input logic [7:0] rd);
    mk_rd = '{port: port, addr: a, we: 1'b0, wdata: 8'h00, rdata: rd, lat: 5, zc: 2, wc: 0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req0_s[k] = 1'b0; req1_s[k] = 1'b0; we1_s[k] = 1'b0;
      addr0_s[k] = 16'h0000; addr1_s[k] = 16'h0000; wdata1_s[k] = 8'h00;
      rd_base[k] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",     u[0].bif.gnt, 2'b00);
    chk("rst_busy",    u[0].bif.busy, 0);
    chk("rst_done",    {u[0].bif.done1, u[0].bif.done0}, 0);
    chk("rst_rdata",   u[0].bif.rdata, 8'h00);
    chk("rst_uio_out", u[0].bif.uio_out, 8'h00);
    chk("rst_uio_oe",  u[0].bif.uio_oe, 8'h00);
    chk("rst_ale",     u[0].bif.bus_ale, 0);
    chk("rst_bus_we",  u[0].bif.bus_we, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, then single write leaving rdata untouched.
    do_txn(0, 0, 16'h12A5, 1'b0, 8'h00, 8'h3B, 8'h3C, 5, 2, 0);
    do_txn(0, 1, 16'h00FF, 1'b1, 8'h81, 8'h3B, 8'h3C, 4, 0, 1);

    // Contention: both reading continuously, grants alternate from port 0.
    exp_q[0].push_back(mk_rd(0, 16'h0100, 8'h51));
    exp_q[0].push_back(mk_rd(1, 16'h0200, 8'h51));
    exp_q[0].push_back(mk_rd(0, 16'h0100, 8'h51));
    exp_q[0].push_back(mk_rd(1, 16'h0200, 8'h51));
    rd_base[0] = 8'h50;
    addr0_s[0] = 16'h0100; addr1_s[0] = 16'h0200; we1_s[0] = 1'b0;
    req0_s[0] = 1'b1; req1_s[0] = 1'b1;
    wait_dones(0, 4);

    // Withdrawal: req1 dropped and addr1 changed while ADDR_LO is on the bus.
    exp_q[0].push_back(mk_rd(1, 16'h4321, 8'h71));
    rd_base[0] = 8'h70;
    addr1_s[0] = 16'h4321; we1_s[0] = 1'b0; req1_s[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req1_s[0] = 1'b0; addr1_s[0] = 16'hBEEF;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        seen = done_o[0][1];
      end
      chk("withdraw_done_seen", seen, 1);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("withdraw_stays_idle", busy_o[0], 0);
    end

    // Leave the pointer on port 1 so the post-reset grant order means something.
    do_txn(0, 0, 16'h0F0F, 1'b0, 8'h00, 8'h60, 8'h61, 5, 2, 0);

    // Reset during DATA_W.
    addr1_s[0] = 16'h5555; we1_s[0] = 1'b1; wdata1_s[0] = 8'hAA; req1_s[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_in_data_w", u[0].bif.uio_out, 8'hAA);
    rst_n = 1'b0;
    req1_s[0] = 1'b0; we1_s[0] = 1'b0;
    @(negedge clk);
    chk("midrst_uio_oe", u[0].bif.uio_oe, 8'h00);
    chk("midrst_gnt",    u[0].bif.gnt, 2'b00);
    chk("midrst_busy",   u[0].bif.busy, 0);
    chk("midrst_done",   done_o[0], 2'b00);
    chk("midrst_rdata",  u[0].bif.rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", done_o[0], 2'b00);

    exp_q[0].push_back(mk_rd(0, 16'h0A0A, 8'h21));
    exp_q[0].push_back(mk_rd(1, 16'h0B0B, 8'h21));
    rd_base[0] = 8'h20;
    addr0_s[0] = 16'h0A0A; addr1_s[0] = 16'h0B0B;
    req0_s[0] = 1'b1; req1_s[0] = 1'b1;
    wait_dones(0, 2);

    // WAIT_CYCLES=3: read captures the third data cycle, then a write.
    do_txn(1, 0, 16'hC0DE, 1'b0, 8'h00, 8'h90, 8'h93, 7, 4, 0);
    do_txn(1, 1, 16'h1234, 1'b1, 8'h5A, 8'h90, 8'h93, 6, 0, 3);

    repeat (3) @(negedge clk);
    chk("queue0_drained", exp_q[0].size(), 0);
    chk("queue1_drained", exp_q[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
